// File: rtl/wb_sram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-asynchronous-SRAM bridge:
// FSM state encoding and the default geometry/timing parameters.
package wb_sram_bridge_pkg;

   localparam int DEF_ADDR_W      = 18;
   localparam int DEF_WAIT_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave running one asynchronous SRAM access per bus cycle,
// with a programmable strobe width and registered SRAM pins and read data.
module wb_sram_bridge
   import wb_sram_bridge_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   input  logic [31:0]       sram_dat_i,
   output logic [31:0]       sram_dat_o,
   output logic              sram_dat_oe_o,
   output logic              sram_ncs_o,
   output logic              sram_noe_o,
   output logic              sram_nwe_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [3:0]        sram_bsel_o
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   if (WAIT_CYCLES < 1) begin : g_paramCheck
      $error("wb_sram_bridge: WAIT_CYCLES must be >= 1");
   end

   state_t              r_state;
   state_t              w_nextState;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_nextCnt;
   logic                r_we;
   logic [3:0]          r_sel;
   logic                r_abort;
   logic                r_ncs;
   logic                r_noe;
   logic                r_nwe;
   logic                r_datOe;
   logic [3:0]          r_bsel;
   logic                r_ack;
   logic [31:0]         r_rdData;
   logic [31:0]         r_wrData;
   logic [ADDR_W-1:0]   r_adr;

   logic                w_req;
   logic                w_take;
   logic                w_nextWe;
   logic [3:0]          w_nextSel;
   logic                w_nextAbort;
   logic                w_nextBusy;
   logic                w_lastStrobe;

   assign w_req        = wb_cyc_i & wb_stb_i;
   assign w_take       = (r_state == IDLE) & w_req;
   assign w_lastStrobe = (r_state == STROBE) && (r_cnt == CNT_W'(1));

   // The pin registers are loaded from the state being entered, so the
   // request attributes must be taken from the bus on the accepting edge.
   assign w_nextWe    = w_take ? wb_we_i  : r_we;
   assign w_nextSel   = w_take ? wb_sel_i : r_sel;
   assign w_nextAbort = w_take ? 1'b0 : (r_abort | ~wb_cyc_i);
   assign w_nextBusy  = (w_nextState != IDLE);

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_req) w_nextState = SETUP;
         end
         SETUP: begin
            w_nextState = STROBE;
            w_nextCnt   = CNT_W'(WAIT_CYCLES);
         end
         STROBE: begin
            if (r_cnt == CNT_W'(1)) w_nextState = HOLD;
            else                    w_nextCnt   = r_cnt - CNT_W'(1);
         end
         HOLD: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_sel    <= 4'h0;
         r_abort  <= 1'b0;
         r_adr    <= '0;
         r_wrData <= 32'h0;
         r_rdData <= 32'h0;
         r_ncs    <= 1'b1;
         r_noe    <= 1'b1;
         r_nwe    <= 1'b1;
         r_datOe  <= 1'b0;
         r_bsel   <= 4'hF;
         r_ack    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_we    <= w_nextWe;
         r_sel   <= w_nextSel;
         r_abort <= w_nextAbort;
         if (w_take) begin
            r_adr    <= wb_adr_i;
            r_wrData <= wb_dat_i;
         end
         if (w_lastStrobe && !r_we) r_rdData <= sram_dat_i;
         // nwe only falls in STROBE, so it rises on entry to HOLD while
         // address, byte enables and data are still held steady.
         r_ncs   <= ~w_nextBusy;
         r_noe   <= ~(~w_nextWe && (w_nextState == SETUP || w_nextState == STROBE));
         r_nwe   <= ~(w_nextWe && (w_nextState == STROBE));
         r_datOe <= w_nextWe && w_nextBusy;
         r_bsel  <= w_nextBusy ? ~w_nextSel : 4'hF;
         r_ack   <= (w_nextState == HOLD) && !w_nextAbort;
      end
   end

   assign wb_dat_o      = r_rdData;
   assign wb_ack_o      = r_ack;
   assign sram_dat_o    = r_wrData;
   assign sram_dat_oe_o = r_datOe;
   assign sram_ncs_o    = r_ncs;
   assign sram_noe_o    = r_noe;
   assign sram_nwe_o    = r_nwe;
   assign sram_addr_o   = r_adr;
   assign sram_bsel_o   = r_bsel;

endmodule
